inst_fetch_unit: RTL and testbench

Fetch stage directly upstream of the instruction interpreter. It owns the fetch PC and issues reads to an instruction memory that has variable latency. Returned 16-bit instructions are buffered in a small prefetch queue and presented to the interpreter over a valid/ready handshake. A redirect input flushes the queue and restarts fetch at a new PC.

---
 rtl/inst_fetch_unit.sv | 153 +++++++++++++++
 tb/tb_inst_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Fetch stage: owns the fetch PC, issues reads to a variable-latency instruction memory and
// buffers returned words in a small prefetch queue presented over a valid/ready handshake.
module inst_fetch_unit #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [7:0]  RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] inst,
  output logic [7:0]  inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

  state_e          state_q, state_d;
  logic [7:0]      fetch_pc_q, fetch_pc_d;
  logic [7:0]      addr_q, addr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [15:0]     inst_q, inst_d;
  logic [7:0]      inst_pc_q, inst_pc_d;
  logic            inst_valid_q, inst_valid_d;

  logic [15:0]     data_mem_q [DEPTH];
  logic [7:0]      pc_mem_q   [DEPTH];

  logic            push, pop, issue_ok, head_is_new;

  // Data returned while draining belongs to a flushed stream and is never pushed.
  assign push     = imem_ack && (state_q == StReq) && !redirect;
  assign pop      = inst_valid_q && inst_ready && !redirect;
  assign issue_ok = count_d < CntW'(DEPTH);

  // Queue bookkeeping
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (issue_ok) state_d = StReq;
      end
      StReq: begin
        if (redirect && !imem_ack) begin
          state_d = StDrain;
        end else if (imem_ack) begin
          state_d = issue_ok ? StReq : StIdle;
        end
      end
      StDrain: begin
        if (imem_ack) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    imem_req   = (state_q != StIdle);
    imem_addr  = addr_q;
    inst       = inst_q;
    inst_pc    = inst_pc_q;
    inst_valid = inst_valid_q;
  end

  // Datapath: PC, held request address and registered queue head
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 8'd1;
    end
    // A drained request keeps presenting its original address until acked.
    addr_d = (state_d == StDrain) ? addr_q : fetch_pc_d;

    head_is_new  = push && (pop ? (count_q == CntW'(1)) : (count_q == '0));
    inst_valid_d = (count_d != '0);
    inst_d       = inst_q;
    inst_pc_d    = inst_pc_q;
    if (inst_valid_d) begin
      if (head_is_new) begin
        inst_d    = imem_data;
        inst_pc_d = fetch_pc_q;
      end else begin
        inst_d    = data_mem_q[rd_ptr_d];
        inst_pc_d = pc_mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      fetch_pc_q   <= RESET_PC;
      addr_q       <= RESET_PC;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      addr_q       <= addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem_q[wr_ptr_q] <= imem_data;
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: variable-latency memory responder, queue-level reference model
// compared every cycle, and directed scenarios with literal expectations.
module tb_inst_fetch_unit;
  localparam int unsigned DEPTH    = 2;
  localparam logic [7:0]  RESET_PC = 8'h00;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] inst;
  logic [7:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;

  int n_checks = 0;
  int n_errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .inst(inst), .inst_pc(inst_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .redirect(redirect),
    .redirect_pc(redirect_pc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] mem_word(input logic [7:0] a);
    return 16'h1000 + {8'h00, a};
  endfunction

  // Memory: acks after mem_lat waiting cycles of a request, data = 16'h1000 + addr.
  int mem_lat  = 0;
  int wait_cnt = 0;
  initial begin
    imem_ack  = 1'b0;
    imem_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !imem_req) begin
        imem_ack = 1'b0;
        wait_cnt = 0;
      end else begin
        if (imem_ack) wait_cnt = 0;
        if (wait_cnt >= mem_lat) begin
          imem_ack  = 1'b1;
          imem_data = mem_word(imem_addr);
        end else begin
          imem_ack = 1'b0;
          wait_cnt++;
        end
      end
    end
  end

  // Reference model: queue of {data, pc} plus fetch bookkeeping.
  typedef struct packed {
    logic [15:0] data;
    logic [7:0]  pc;
  } ent_t;

  ent_t        mq[$];
  logic [7:0]  m_pc, m_addr, m_inst_pc;
  logic [15:0] m_inst;
  bit          m_req, m_drain, m_ack;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_pc = RESET_PC; m_addr = RESET_PC; m_req = 0; m_drain = 0;
      m_inst = '0; m_inst_pc = '0;
    end else begin
      m_ack = imem_ack && m_req;
      if (redirect) begin
        mq.delete();
        if (m_req && !m_ack) begin
          m_drain = 1;
        end else begin
          m_req = 1; m_drain = 0; m_addr = redirect_pc;
        end
        m_pc = redirect_pc;
      end else begin
        if (mq.size() > 0 && inst_ready) void'(mq.pop_front());
        if (m_drain) begin
          if (m_ack) begin
            m_drain = 0; m_req = 1; m_addr = m_pc;
          end
        end else begin
          if (m_ack) begin
            mq.push_back(ent_t'{data: imem_data, pc: m_pc});
            m_pc = m_pc + 8'd1;
          end
          if (!m_req || m_ack) begin
            m_req  = (mq.size() < DEPTH);
            m_addr = m_pc;
          end
        end
      end
    end
    if (mq.size() > 0) begin
      m_inst    = mq[0].data;
      m_inst_pc = mq[0].pc;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_req", imem_req, m_req);
      if (m_req) chk("imem_addr", imem_addr, m_addr);
      chk("inst_valid", inst_valid, mq.size() > 0);
      chk("inst", inst, m_inst);
      chk("inst_pc", inst_pc, m_inst_pc);
    end
  end

  // Log of accepted instructions and memory acks.
  typedef struct {
    logic [7:0]  pc;
    logic [15:0] data;
    int          cyc;
  } log_t;

  log_t acc[$];
  int   cyc    = 0;
  int   n_acks = 0;
  bit   seen_bad = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst_n && inst_valid && inst_ready && !redirect) acc.push_back('{inst_pc, inst, cyc});
    if (rst_n && imem_req && imem_ack) n_acks++;
  end

  always @(negedge clk) begin
    if (inst_valid && inst == 16'h1005) seen_bad = 1;
  end

  task automatic chk_log(input string name, input int idx, input logic [7:0] pc);
    if (idx >= acc.size()) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: log entry %0d missing, expected pc %0h", name, idx, pc);
    end else begin
      chk({name, " pc"}, acc[idx].pc, pc);
      chk({name, " data"}, acc[idx].data, mem_word(pc));
    end
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max && !inst_valid; i++) tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; inst_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    tick(2);
    chk_en = 1;
    chk("rst imem_req", imem_req, 0);
    chk("rst imem_addr", imem_addr, RESET_PC);
    chk("rst inst_valid", inst_valid, 0);
    chk("rst inst", inst, 0);
    chk("rst inst_pc", inst_pc, 0);

    // Streaming with single-cycle memory response
    inst_ready = 1'b1;
    acc.delete();
    rst_n = 1'b1;
    tick(12);
    chk("stream length", acc.size() >= 8, 1);
    for (int i = 0; i < 8; i++) begin
      chk_log("stream", i, 8'(i));
      if (i < acc.size()) chk("stream no gap", acc[i].cyc - acc[0].cyc, i);
    end

    // Backpressure fills the queue, then release
    rst_n = 1'b0; inst_ready = 1'b0;
    tick(2);
    n_acks = 0;
    rst_n = 1'b1;
    tick(8);
    chk("bp acks", n_acks, 2);
    chk("bp req idle", imem_req, 0);
    chk("bp head valid", inst_valid, 1);
    chk("bp head pc", inst_pc, 8'h00);
    chk("bp head data", inst, 16'h1000);
    acc.delete();
    inst_ready = 1'b1;
    tick(6);
    for (int i = 0; i < 5; i++) chk_log("bp order", i, 8'(i));

    // PC wrap
    acc.delete();
    redirect = 1'b1; redirect_pc = 8'hFE;
    tick(1);
    redirect = 1'b0;
    tick(8);
    chk_log("wrap", 0, 8'hFE);
    chk_log("wrap", 1, 8'hFF);
    chk_log("wrap", 2, 8'h00);
    chk_log("wrap", 3, 8'h01);

    // Redirect while a slow request to 5 is outstanding
    inst_ready = 1'b0;
    tick(6);
    mem_lat = 3;
    tick(1);
    redirect = 1'b1; redirect_pc = 8'h05; inst_ready = 1'b1;
    tick(1);
    redirect = 1'b0;
    chk("drain req5", imem_req, 1);
    chk("drain addr5", imem_addr, 8'h05);
    tick(1);
    redirect = 1'b1; redirect_pc = 8'h40;
    tick(1);
    redirect = 1'b0;
    seen_bad = 0;
    acc.delete();
    chk("drain hold addr", imem_addr, 8'h05);
    chk("drain flushed", inst_valid, 0);
    for (int i = 0; i < 10 && imem_addr == 8'h05; i++) tick(1);
    chk("drain next addr", imem_addr, 8'h40);
    wait_valid(12);
    chk("drain first valid", inst_valid, 1);
    chk("drain first pc", inst_pc, 8'h40);
    chk("drain first data", inst, 16'h1040);
    tick(1);
    chk("drain data5 hidden", seen_bad, 0);
    chk_log("drain log", 0, 8'h40);

    // Redirect coinciding with an ack while the consumer is popping
    mem_lat = 0;
    tick(6);
    chk("coinc pre valid", inst_valid, 1);
    acc.delete();
    redirect = 1'b1; redirect_pc = 8'h80;
    tick(1);
    redirect = 1'b0;
    chk("coinc valid", inst_valid, 0);
    chk("coinc req", imem_req, 1);
    chk("coinc addr", imem_addr, 8'h80);
    tick(5);
    chk_log("coinc", 0, 8'h80);
    chk_log("coinc", 1, 8'h81);

    // Reset in the middle of a drain
    mem_lat = 3;
    tick(1);
    redirect = 1'b1; redirect_pc = 8'h30;
    tick(1);
    redirect = 1'b0;
    chk("rd drain req", imem_req, 1);
    chk("rd drain stale", imem_addr == 8'h30, 0);
    tick(1);
    rst_n = 1'b0;
    tick(1);
    chk("rd req", imem_req, 0);
    chk("rd valid", inst_valid, 0);
    chk("rd addr", imem_addr, RESET_PC);
    chk("rd inst", inst, 0);
    chk("rd inst_pc", inst_pc, 0);
    rst_n = 1'b1;
    tick(1);
    chk("rd restart req", imem_req, 1);
    chk("rd restart addr", imem_addr, RESET_PC);
    wait_valid(12);
    chk("rd restart valid", inst_valid, 1);
    chk("rd restart pc", inst_pc, RESET_PC);
    chk("rd restart data", inst, 16'h1000);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
